// File: rtl/instr_fetch_64.sv
// Instruction fetch sequencer: owns the fetch PC, runs the memory read
// handshake and strobes each fetched word into the instruction register.
module instr_fetch_64 #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        mem_rd,
    output logic [63:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instruction,
    output logic        load_ir,
    output logic [63:0] pc,
    output logic        busy,
    output logic        misaligned
);
    // state   | meaning
    // IDLE    | waiting for fetch_en
    // REQ     | read outstanding, mem_rd high until mem_ready
    // DELIVER | load_ir strobe, instruction/pc valid
    typedef enum logic [1:0] {IDLE, REQ, DELIVER} state_t;

    state_t      state, state_nxt;
    logic [63:0] fetch_pc, fetch_pc_nxt;
    logic [63:0] pc_nxt, mem_addr_nxt;
    logic [31:0] instruction_nxt;
    logic        squash, squash_nxt;
    logic        redir_ok, redir_bad;

    assign redir_ok  = redirect && (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redirect && (redirect_pc[1:0] != 2'b00);

    assign mem_rd  = (state == REQ);
    assign load_ir = (state == DELIVER);
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt       = state;
        fetch_pc_nxt    = fetch_pc;
        pc_nxt          = pc;
        mem_addr_nxt    = mem_addr;
        instruction_nxt = instruction;
        squash_nxt      = squash;
        case (state)
            IDLE: begin
                if (redir_ok)
                    fetch_pc_nxt = redirect_pc;
                if (fetch_en) begin
                    state_nxt    = REQ;
                    mem_addr_nxt = redir_ok ? redirect_pc : fetch_pc;
                end
            end
            REQ: begin
                if (redir_ok)
                    fetch_pc_nxt = redirect_pc;
                if (mem_ready) begin
                    // A redirect landing with the data squashes it just like an earlier one.
                    if (squash || redir_ok) begin
                        state_nxt  = IDLE;
                        squash_nxt = 1'b0;
                    end else begin
                        state_nxt       = DELIVER;
                        instruction_nxt = mem_rdata;
                        pc_nxt          = mem_addr;
                        fetch_pc_nxt    = mem_addr + 64'd4;
                    end
                end else if (redir_ok) begin
                    squash_nxt = 1'b1;
                end
            end
            DELIVER: begin
                state_nxt = IDLE;
                if (redir_ok)
                    fetch_pc_nxt = redirect_pc;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            pc          <= 64'h0;
            mem_addr    <= 64'h0;
            instruction <= 32'h0;
            squash      <= 1'b0;
            misaligned  <= 1'b0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            pc          <= pc_nxt;
            mem_addr    <= mem_addr_nxt;
            instruction <= instruction_nxt;
            squash      <= squash_nxt;
            misaligned  <= redir_bad;
        end
    end
endmodule

// File: tb/tb_instr_fetch_64.sv
// Bench for instr_fetch_64: directed cycle table followed by random traffic
// checked against a transaction-level reference model.
module tb_instr_fetch_64;
    localparam logic [63:0] TB_RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset, fetch_en, redirect, mem_ready;
    logic [63:0] redirect_pc;
    logic [31:0] mem_rdata;
    logic        mem_rd, load_ir, busy, misaligned;
    logic [63:0] mem_addr, pc;
    logic [31:0] instruction;

    int tests = 0;
    int failed = 0;

    instr_fetch_64 #(.RESET_PC(TB_RESET_PC)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect(redirect),
        .redirect_pc(redirect_pc), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .instruction(instruction),
        .load_ir(load_ir), .pc(pc), .busy(busy), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, fe, rd;
        logic [63:0] rpc;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_mrd;
        logic [63:0] e_maddr;
        logic        e_lir;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
        logic        e_busy, e_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic rst, logic fe, logic rd, logic [63:0] rpc,
                                logic rdy, logic [31:0] rdata, logic e_mrd,
                                logic [63:0] e_maddr, logic e_lir, logic [31:0] e_instr,
                                logic [63:0] e_pc, logic e_busy, logic e_mis);
        vec_t v;
        v.rst = rst; v.fe = fe; v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.rdata = rdata;
        v.e_mrd = e_mrd; v.e_maddr = e_maddr; v.e_lir = e_lir; v.e_instr = e_instr;
        v.e_pc = e_pc; v.e_busy = e_busy; v.e_mis = e_mis;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fe, input logic rd, input logic [63:0] rpc,
                         input logic rdy, input logic [31:0] rdata);
        reset = rst; fetch_en = fe; redirect = rd; redirect_pc = rpc;
        mem_ready = rdy; mem_rdata = rdata;
    endtask

    task automatic check_all(input int idx, input logic e_mrd, input logic [63:0] e_maddr,
                             input logic e_lir, input logic [31:0] e_instr, input logic [63:0] e_pc,
                             input logic e_busy, input logic e_mis);
        chk("mem_rd", idx, {63'h0, mem_rd}, {63'h0, e_mrd});
        chk("mem_addr", idx, mem_addr, e_maddr);
        chk("load_ir", idx, {63'h0, load_ir}, {63'h0, e_lir});
        chk("instruction", idx, {32'h0, instruction}, {32'h0, e_instr});
        chk("pc", idx, pc, e_pc);
        chk("busy", idx, {63'h0, busy}, {63'h0, e_busy});
        chk("misaligned", idx, {63'h0, misaligned}, {63'h0, e_mis});
    endtask

    // Reference model: a read transaction, a pending delivery and the next address.
    logic        m_in_txn, m_dead, m_deliver, m_mis;
    logic [63:0] m_next, m_addr, m_pc;
    logic [31:0] m_instr;

    task automatic model_step(input logic rst, input logic fe, input logic rd, input logic [63:0] rpc,
                              input logic rdy, input logic [31:0] rdata);
        logic ok;
        ok = rd && (rpc[1:0] == 2'b00);
        if (rst) begin
            m_in_txn = 0; m_dead = 0; m_deliver = 0; m_mis = 0;
            m_next = TB_RESET_PC; m_addr = 0; m_pc = 0; m_instr = 0;
            return;
        end
        m_mis = rd && !ok;
        if (m_deliver) begin
            m_deliver = 0;
            if (ok) m_next = rpc;
        end else if (m_in_txn) begin
            if (ok) begin m_next = rpc; m_dead = 1; end
            if (rdy) begin
                m_in_txn = 0;
                if (!m_dead) begin
                    m_deliver = 1; m_pc = m_addr; m_instr = rdata; m_next = m_addr + 64'd4;
                end
                m_dead = 0;
            end
        end else begin
            if (ok) m_next = rpc;
            if (fe) begin m_in_txn = 1; m_dead = 0; m_addr = m_next; end
        end
    endtask

    initial begin
        logic [63:0] TOP;
        logic        r_rst, r_fe, r_rd, r_rdy;
        logic [63:0] r_rpc;
        logic [31:0] r_rdata;
        TOP = 64'hFFFF_FFFF_FFFF_FFFC;

        //    rst fe rd rpc            rdy rdata          mrd maddr       lir instr          pc        busy mis
        add(1, 0, 0, 0,             0, 0,             0, 0,           0, 0,             0,        0, 0);
        add(0, 1, 0, 0,             0, 0,             1, 0,           0, 0,             0,        1, 0);
        add(0, 0, 0, 0,             1, 32'h8C220004,  0, 0,           1, 32'h8C220004,  0,        1, 0);
        add(0, 0, 0, 0,             0, 0,             0, 0,           0, 32'h8C220004,  0,        0, 0);
        add(0, 1, 0, 0,             0, 0,             1, 4,           0, 32'h8C220004,  0,        1, 0);
        add(0, 0, 0, 0,             0, 0,             1, 4,           0, 32'h8C220004,  0,        1, 0);
        add(0, 0, 0, 0,             0, 0,             1, 4,           0, 32'h8C220004,  0,        1, 0);
        add(0, 0, 0, 0,             0, 0,             1, 4,           0, 32'h8C220004,  0,        1, 0);
        add(0, 0, 0, 0,             1, 32'h11111111,  0, 4,           1, 32'h11111111,  4,        1, 0);
        add(0, 0, 0, 0,             0, 0,             0, 4,           0, 32'h11111111,  4,        0, 0);
        add(0, 1, 0, 0,             0, 0,             1, 8,           0, 32'h11111111,  4,        1, 0);
        add(0, 0, 1, 64'h1000,      0, 0,             1, 8,           0, 32'h11111111,  4,        1, 0);
        add(0, 0, 0, 0,             1, 32'hDEADBEEF,  0, 8,           0, 32'h11111111,  4,        0, 0);
        add(0, 1, 0, 0,             0, 0,             1, 64'h1000,    0, 32'h11111111,  4,        1, 0);
        add(0, 0, 0, 0,             1, 32'h22222222,  0, 64'h1000,    1, 32'h22222222,  64'h1000, 1, 0);
        add(0, 0, 1, 64'h1002,      0, 0,             0, 64'h1000,    0, 32'h22222222,  64'h1000, 0, 1);
        add(0, 1, 0, 0,             0, 0,             1, 64'h1004,    0, 32'h22222222,  64'h1000, 1, 0);
        add(0, 0, 0, 0,             1, 32'h33333333,  0, 64'h1004,    1, 32'h33333333,  64'h1004, 1, 0);
        add(0, 0, 1, TOP,           0, 0,             0, 64'h1004,    0, 32'h33333333,  64'h1004, 0, 0);
        add(0, 1, 0, 0,             0, 0,             1, TOP,         0, 32'h33333333,  64'h1004, 1, 0);
        add(0, 0, 0, 0,             1, 32'h44444444,  0, TOP,         1, 32'h44444444,  TOP,      1, 0);
        add(0, 0, 0, 0,             0, 0,             0, TOP,         0, 32'h44444444,  TOP,      0, 0);
        add(0, 1, 0, 0,             0, 0,             1, 0,           0, 32'h44444444,  TOP,      1, 0);
        add(0, 0, 0, 0,             1, 32'h55555555,  0, 0,           1, 32'h55555555,  0,        1, 0);
        add(0, 0, 0, 0,             0, 0,             0, 0,           0, 32'h55555555,  0,        0, 0);
        add(0, 1, 0, 0,             0, 0,             1, 4,           0, 32'h55555555,  0,        1, 0);
        add(0, 0, 0, 0,             0, 0,             1, 4,           0, 32'h55555555,  0,        1, 0);
        add(1, 0, 0, 0,             0, 0,             0, 0,           0, 0,             0,        0, 0);
        add(0, 1, 0, 0,             0, 0,             1, TB_RESET_PC, 0, 0,             0,        1, 0);
        add(0, 0, 0, 0,             1, 32'h66666666,  0, TB_RESET_PC, 1, 32'h66666666,  TB_RESET_PC, 1, 0);
        add(0, 0, 0, 0,             0, 0,             0, TB_RESET_PC, 0, 32'h66666666,  TB_RESET_PC, 0, 0);
        add(0, 1, 1, 64'h2000,      0, 0,             1, 64'h2000,    0, 32'h66666666,  TB_RESET_PC, 1, 0);
        add(0, 0, 0, 0,             1, 32'h77777777,  0, 64'h2000,    1, 32'h77777777,  64'h2000, 1, 0);
        add(0, 0, 0, 0,             0, 0,             0, 64'h2000,    0, 32'h77777777,  64'h2000, 0, 0);
        add(0, 0, 1, 64'h3002,      0, 0,             0, 64'h2000,    0, 32'h77777777,  64'h2000, 0, 1);
        add(0, 1, 0, 0,             0, 0,             1, 64'h2004,    0, 32'h77777777,  64'h2000, 1, 0);
        add(0, 0, 0, 0,             1, 32'h88888888,  0, 64'h2004,    1, 32'h88888888,  64'h2004, 1, 0);
        add(0, 0, 0, 0,             0, 0,             0, 64'h2004,    0, 32'h88888888,  64'h2004, 0, 0);
        add(0, 1, 0, 0,             0, 0,             1, 64'h2008,    0, 32'h88888888,  64'h2004, 1, 0);
        add(0, 0, 1, 64'h4000,      1, 32'h99999999,  0, 64'h2008,    0, 32'h88888888,  64'h2004, 0, 0);
        add(0, 1, 0, 0,             0, 0,             1, 64'h4000,    0, 32'h88888888,  64'h2004, 1, 0);
        add(0, 1, 0, 0,             1, 32'hAAAAAAAA,  0, 64'h4000,    1, 32'hAAAAAAAA,  64'h4000, 1, 0);
        add(0, 1, 0, 0,             0, 0,             0, 64'h4000,    0, 32'hAAAAAAAA,  64'h4000, 0, 0);

        drive(1, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].fe, vecs[i].rd, vecs[i].rpc, vecs[i].rdy, vecs[i].rdata);
            @(posedge clk);
            @(negedge clk);
            check_all(i, vecs[i].e_mrd, vecs[i].e_maddr, vecs[i].e_lir, vecs[i].e_instr,
                      vecs[i].e_pc, vecs[i].e_busy, vecs[i].e_mis);
        end

        drive(1, 0, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < 4000; c++) begin
            r_rst = ($urandom_range(0, 149) == 0);
            r_fe  = ($urandom_range(0, 2) != 0);
            r_rd  = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 7))
                0: r_rpc = TOP - 64'($urandom_range(0, 3) * 4);
                1: r_rpc = {$urandom, $urandom} | 64'h1;
                2: r_rpc = {$urandom, $urandom} | 64'h2;
                default: r_rpc = {32'h0, $urandom} & ~64'h3;
            endcase
            r_rdy   = ($urandom_range(0, 2) == 0);
            r_rdata = $urandom;
            drive(r_rst, r_fe, r_rd, r_rpc, r_rdy, r_rdata);
            model_step(r_rst, r_fe, r_rd, r_rpc, r_rdy, r_rdata);
            @(posedge clk);
            @(negedge clk);
            check_all(1000 + c, m_in_txn, m_addr, m_deliver, m_instr, m_pc,
                      m_in_txn || m_deliver, m_mis);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/instr_fetch_64.md
# instr_fetch_64

Instruction fetch sequencer that drives the instruction register. On request from the control unit it computes the fetch address, runs a read handshake with instruction memory (variable wait states), and delivers the 32-bit word with a one-cycle `load_ir` strobe. It owns the fetch program counter: sequential +4 advance, plus control-flow redirects from the branch/jump logic.

## Interface
- `RESET_PC`, default 64'h0: fetch address after reset; must be 4-byte aligned.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fetch_en`  in  1  control unit requests the next instruction; sampled only in IDLE.
- `redirect`  in  1  load a new fetch address (branch/jump taken).
- `redirect_pc`  in  64  target address for `redirect`.
- `mem_rd`  out  1  memory read request; held high until `mem_ready`.
- `mem_addr`  out  64  read address; stable while `mem_rd`=1.
- `mem_ready`  in  1  memory completion; `mem_rdata` valid in the same cycle.
- `mem_rdata`  in  32  instruction word from memory.
- `instruction`  out  32  word presented to the instruction register.
- `load_ir`  out  1  one-cycle strobe: instruction register captures `instruction`.
- `pc`  out  64  address of the word last delivered with `load_ir`.
- `busy`  out  1  high in any state other than IDLE.
- `misaligned`  out  1  one-cycle pulse: redirect rejected, `redirect_pc[1:0]`≠0.

## Operation
- Registers: `fetch_pc` (next fetch address), `pc`, `instruction`, `squash` flag, state.
- States: IDLE, REQ, DELIVER.
- IDLE: `fetch_en`=1 → REQ, `mem_addr`<=`fetch_pc`. Otherwise remain.
- REQ: `mem_rd`=1. On `mem_ready`=1:
  - `squash`=0: capture `mem_rdata` into `instruction`, `pc`<=`mem_addr`, `fetch_pc`<=`mem_addr`+4 (mod 2^64), → DELIVER.
  - `squash`=1: discard data, clear `squash`, → IDLE; no `load_ir`, `pc` unchanged.
- DELIVER: `load_ir`=1 for exactly this cycle, → IDLE.
- Redirect, aligned target:
  - IDLE: `fetch_pc`<=`redirect_pc`. If `fetch_en` is also high, the fetch uses `redirect_pc` (`mem_addr`<=`redirect_pc`).
  - REQ: the transaction is never aborted. Set `squash`, `fetch_pc`<=`redirect_pc`. If `mem_ready` is in the same cycle, data is discarded and the state goes to IDLE.
  - DELIVER: the delivery completes, and `fetch_pc`<=`redirect_pc` overrides the +4 value.
- Redirect, misaligned target: ignored, with no state change. `misaligned` pulses the next cycle.
- `fetch_en` outside IDLE is ignored; it is not queued.
- Reset, any state including mid-REQ: state IDLE, `fetch_pc`=`RESET_PC`, `pc`=0, `instruction`=0, `squash`=0. All outputs are 0 the cycle after reset. `mem_rd` drops even when a transaction is outstanding. Memory must tolerate a dropped request.

## Timing
- Zero-wait memory: `fetch_en` at cycle N → `mem_rd` at N+1 → `mem_ready` at N+1 → `load_ir` at N+2. The IR holds the word from edge N+3. Back-to-back fetch rate is 1 per 3 cycles.
- Each memory wait cycle adds one cycle of latency.
- `instruction` and `pc` change only on the edge entering DELIVER, and hold until the next delivery.
- `busy` is combinational from state. `mem_rd`, `mem_addr`, `load_ir` and `misaligned` are registered or state-decoded; none are combinational from inputs.

## Test plan
- Reset then `fetch_en` pulse, memory returns 32'h8C220004 with 0 waits → `mem_addr`=0 at N+1, `load_ir` at N+2, `instruction`=32'h8C220004, `pc`=0. Next fetch uses `mem_addr`=4.
- `mem_ready` delayed 3 cycles → `mem_rd` and `mem_addr` stable for 4 cycles, `load_ir` at N+5, exactly one pulse.
- Redirect to 64'h1000 mid-REQ → old data discarded, no `load_ir`, `pc` unchanged. Next `fetch_en` gives `mem_addr`=64'h1000.
- Redirect with `redirect_pc`=64'h1002 → `misaligned` pulse, next fetch still at the sequential address.
- `fetch_pc`=64'hFFFF_FFFF_FFFF_FFFC, fetch completes → `pc`=64'hFFFF_FFFF_FFFF_FFFC, next `mem_addr`=0 (wrap).
- Reset asserted during REQ with `mem_ready` low → next cycle `mem_rd`=0, `busy`=0. Next `fetch_en` gives `mem_addr`=`RESET_PC`.
